// File: rtl/btn_press_generator.sv
// Button press waveform synthesiser: emits num_presses high/low pulses on btn,
// each high for max(high_cycles,1) and low for max(low_cycles,1) clock cycles.
module btn_press_generator #(
    parameter int count_width = 2,
    parameter int hold_width  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [count_width-1:0] num_presses,
    input  logic [hold_width-1:0]  high_cycles,
    input  logic [hold_width-1:0]  low_cycles,
    output logic                   btn,
    output logic                   busy,
    output logic                   done,
    output logic [count_width-1:0] presses_sent
);

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE, FINISH} state_t;

    state_t                 state_q, state_d;
    logic                   btn_q, btn_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [count_width-1:0] presses_sent_q, presses_sent_d;
    logic [count_width-1:0] num_q, num_d;
    logic [hold_width-1:0]  high_q, high_d;
    logic [hold_width-1:0]  low_q, low_d;
    logic [hold_width-1:0]  timer_q, timer_d;
    logic [hold_width-1:0]  high_eff, low_eff;

    // Zero-length phases are stretched to one cycle so every pulse is visible.
    assign high_eff = (high_cycles == '0) ? hold_width'(1) : high_cycles;
    assign low_eff  = (low_cycles == '0) ? hold_width'(1) : low_cycles;

    always_comb begin
        state_d        = state_q;
        btn_d          = btn_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        presses_sent_d = presses_sent_q;
        num_d          = num_q;
        high_d         = high_q;
        low_d          = low_q;
        timer_d        = timer_q;
        case (state_q)
            IDLE: begin
                btn_d  = 1'b0;
                busy_d = 1'b0;
                if (start) begin
                    presses_sent_d = '0;
                    if (num_presses != '0) begin
                        num_d   = num_presses;
                        high_d  = high_eff;
                        low_d   = low_eff;
                        timer_d = high_eff;
                        btn_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = PRESS;
                    end else begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            PRESS: begin
                if (timer_q == hold_width'(1)) begin
                    btn_d          = 1'b0;
                    timer_d        = low_q;
                    presses_sent_d = presses_sent_q + count_width'(1);
                    state_d        = RELEASE;
                end else begin
                    timer_d = timer_q - hold_width'(1);
                end
            end
            RELEASE: begin
                if (timer_q == hold_width'(1)) begin
                    if (presses_sent_q == num_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        timer_d = '0;
                        state_d = FINISH;
                    end else begin
                        btn_d   = 1'b1;
                        timer_d = high_q;
                        state_d = PRESS;
                    end
                end else begin
                    timer_d = timer_q - hold_width'(1);
                end
            end
            FINISH: begin
                btn_d   = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            btn_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            presses_sent_q <= '0;
            num_q          <= '0;
            high_q         <= '0;
            low_q          <= '0;
            timer_q        <= '0;
        end else begin
            state_q        <= state_d;
            btn_q          <= btn_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            presses_sent_q <= presses_sent_d;
            num_q          <= num_d;
            high_q         <= high_d;
            low_q          <= low_d;
            timer_q        <= timer_d;
        end
    end

    assign btn          = btn_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign presses_sent = presses_sent_q;

endmodule

// File: tb/tb_btn_press_generator.sv
// Self-checking bench for btn_press_generator: per-cycle expected waveform
// queue built from the press/release timing formula, plus vector table.
module tb_btn_press_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] num_presses;
    logic [7:0] high_cycles;
    logic [7:0] low_cycles;
    logic       btn, busy, done;
    logic [1:0] presses_sent;

    int checks   = 0;
    int failures = 0;

    btn_press_generator #(.count_width(2), .hold_width(8)) dut (
        .clk(clk), .reset(reset), .start(start), .num_presses(num_presses),
        .high_cycles(high_cycles), .low_cycles(low_cycles),
        .btn(btn), .busy(busy), .done(done), .presses_sent(presses_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       btn;
        logic       busy;
        logic       done;
        logic [1:0] ps;
    } obs_t;

    typedef struct {
        int n;
        int h;
        int l;
        int mode;      // 0 plain, 1 meddle with inputs mid-run, 2 reset mid-run
        int rst_idx;
        int exp_busy;
        int exp_rel;
    } vec_t;

    obs_t sb[$];

    function automatic obs_t cur();
        obs_t o;
        o.btn  = btn;
        o.busy = busy;
        o.done = done;
        o.ps   = presses_sent;
        return o;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
        end
    endtask

    // Expected waveform straight from the timing description.
    task automatic build(input int n, input int h, input int l);
        int he, le;
        obs_t e;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < he; c++) begin
                e = '{btn: 1'b1, busy: 1'b1, done: 1'b0, ps: 2'(p)};
                sb.push_back(e);
            end
            for (int c = 0; c < le; c++) begin
                e = '{btn: 1'b0, busy: 1'b1, done: 1'b0, ps: 2'(p + 1)};
                sb.push_back(e);
            end
        end
        e = '{btn: 1'b0, busy: 1'b0, done: 1'b1, ps: 2'(n)};
        sb.push_back(e);
        e = '{btn: 1'b0, busy: 1'b0, done: 1'b0, ps: 2'(n)};
        sb.push_back(e);
    endtask

    task automatic run(input vec_t v);
        obs_t e, a;
        int   idx = 0;
        int   busy_cnt = 0;
        int   rel_cnt = 0;
        logic prev_btn = 1'b0;
        @(negedge clk);
        num_presses = 2'(v.n);
        high_cycles = 8'(v.h);
        low_cycles  = 8'(v.l);
        start       = 1'b1;
        build(v.n, v.h, v.l);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            a = cur();
            chk("seq_cycle", idx, int'(a), int'(e));
            busy_cnt += int'(a.busy);
            if (prev_btn && !a.btn) rel_cnt++;
            prev_btn = a.btn;
            if (v.mode == 1) begin
                if (idx == 5) begin
                    num_presses = 2'd1;
                    high_cycles = 8'd9;
                    low_cycles  = 8'd0;
                end
                if (sb.size() == 0) start = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (v.mode == 2 && idx == v.rst_idx) begin
                reset = 1'b0;
                sb.delete();
                @(negedge clk);
                chk("reset_mid", idx, int'(cur()), 0);
                reset = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("post_reset_idle", i, int'(cur()), 0);
                end
                return;
            end
            idx++;
        end
        @(negedge clk);
        e = '{btn: 1'b0, busy: 1'b0, done: 1'b0, ps: 2'(v.n)};
        chk("idle_after", idx, int'(cur()), int'(e));
        chk("busy_len", v.n, busy_cnt, v.exp_busy);
        chk("counter_reads", v.n, rel_cnt % 4, v.exp_rel);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{n: 3, h: 4,   l: 2, mode: 0, rst_idx: 0, exp_busy: 18,  exp_rel: 3};
        vecs[1] = '{n: 0, h: 5,   l: 5, mode: 0, rst_idx: 0, exp_busy: 0,   exp_rel: 0};
        vecs[2] = '{n: 2, h: 0,   l: 0, mode: 0, rst_idx: 0, exp_busy: 4,   exp_rel: 2};
        vecs[3] = '{n: 1, h: 0,   l: 5, mode: 0, rst_idx: 0, exp_busy: 6,   exp_rel: 1};
        vecs[4] = '{n: 3, h: 255, l: 1, mode: 0, rst_idx: 0, exp_busy: 768, exp_rel: 3};
        vecs[5] = '{n: 3, h: 4,   l: 2, mode: 1, rst_idx: 0, exp_busy: 18,  exp_rel: 3};
        vecs[6] = '{n: 3, h: 2,   l: 2, mode: 2, rst_idx: 4, exp_busy: 0,   exp_rel: 0};

        reset = 1'b0; start = 1'b0;
        num_presses = '0; high_cycles = '0; low_cycles = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", 0, int'(cur()), 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_hold", i, int'(cur()), 0);
        end

        foreach (vecs[k]) run(vecs[k]);

        // Normal single press after the mid-run reset.
        run('{n: 1, h: 3, l: 2, mode: 0, rst_idx: 0, exp_busy: 5, exp_rel: 1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
